// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Purpose:
//   Maps MIDI note events onto a pool of NUM_VOICES synth voices. A per-voice
//   table (active flag, key, saturating age) is searched one voice per clock.
//   A note-on reuses a voice already holding the key, otherwise takes the
//   lowest free voice, otherwise steals the oldest voice. A note-off releases
//   the voice holding the key. Each accepted event yields at most one write
//   command towards the voice datapath.
//
// Build option:
//   VOICE_STEAL_EN - when defined, a note-on that finds neither a matching nor
//                    a free voice steals the oldest one (o_steal pulses).
//                    When undefined, such a note-on is dropped and o_steal
//                    is tied low.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_note_valid          event present
//   o_note_ready          block can accept an event (high only in IDLE)
//   i_note_on             1 = note-on, 0 = note-off
//   i_note_key            MIDI key number
//   i_tuning_code         phase increment for the key
//   i_velocity            MIDI velocity (0 on a note-on means note-off)
//   o_voice_wr            one-cycle write strobe
//   o_voice_index         target voice
//   o_voice_gate          1 = start/retrigger, 0 = release
//   o_voice_tuning        tuning code for the target voice
//   o_voice_velocity      velocity (0 on release)
//   o_active_mask         bit v = voice v gated
//   o_steal               pulse with o_voice_wr when a voice was stolen
//   o_drop                pulse when an event produces no write
//
// Timing: event accepted in cycle T, SCAN in T+1..T+NUM_VOICES, write/drop
// strobe in T+NUM_VOICES+1, ready again in T+NUM_VOICES+2.
// ---------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8,
    localparam int VI_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_note_valid,
    output logic                  o_note_ready,
    input  logic                  i_note_on,
    input  logic [6:0]            i_note_key,
    input  logic [31:0]           i_tuning_code,
    input  logic [6:0]            i_velocity,
    output logic                  o_voice_wr,
    output logic [VI_W-1:0]       o_voice_index,
    output logic                  o_voice_gate,
    output logic [31:0]           o_voice_tuning,
    output logic [6:0]            o_voice_velocity,
    output logic [NUM_VOICES-1:0] o_active_mask,
    output logic                  o_steal,
    output logic                  o_drop
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    // FSM and latched event
    logic [1:0]      state_reg;
    logic [VI_W-1:0] scan_idx_reg;
    logic            on_lat_reg;      // effective note-on (velocity != 0)
    logic [6:0]      key_lat_reg;
    logic [31:0]     tuning_lat_reg;
    logic [6:0]      vel_lat_reg;

    // Search candidates accumulated across the scan
    logic            match_found_reg, match_found_next;
    logic [VI_W-1:0] match_idx_reg,   match_idx_next;
    logic            free_found_reg,  free_found_next;
    logic [VI_W-1:0] free_idx_reg,    free_idx_next;
`ifdef VOICE_STEAL_EN
    logic             old_found_reg, old_found_next;
    logic [VI_W-1:0]  old_idx_reg,   old_idx_next;
    logic [AGE_W-1:0] old_age_reg,   old_age_next;
    logic             steal_reg;
    logic             dec_steal;
`endif

    // Voice table
    logic [NUM_VOICES-1:0]            active_reg, active_next;
    logic [NUM_VOICES-1:0][6:0]       key_tab_reg, key_tab_next;
    logic [NUM_VOICES-1:0][AGE_W-1:0] age_reg, age_next;

    // Output registers
    logic            voice_wr_reg;
    logic            drop_reg;
    logic [VI_W-1:0] voice_index_reg;
    logic            voice_gate_reg;
    logic [31:0]     voice_tuning_reg;
    logic [6:0]      voice_vel_reg;

    // Decision taken on the last scan cycle, using the candidates that
    // already include the voice being examined in that cycle.
    logic            dec_write;
    logic            dec_gate;
    logic [VI_W-1:0] dec_index;

    logic            cur_active;
    logic [6:0]      cur_key;
    logic            scan_last;

    assign cur_active = active_reg[scan_idx_reg];
    assign cur_key    = key_tab_reg[scan_idx_reg];
    assign scan_last  = (scan_idx_reg == VI_W'(NUM_VOICES - 1));

    // -----------------------------------------------------------------------
    // Candidate update for the voice currently under examination
    // -----------------------------------------------------------------------
    always_comb begin
        match_found_next = match_found_reg;
        match_idx_next   = match_idx_reg;
        free_found_next  = free_found_reg;
        free_idx_next    = free_idx_reg;
        if (!match_found_reg && cur_active && (cur_key == key_lat_reg)) begin
            match_found_next = 1'b1;
            match_idx_next   = scan_idx_reg;
        end
        if (!free_found_reg && !cur_active) begin
            free_found_next = 1'b1;
            free_idx_next   = scan_idx_reg;
        end
    end

`ifdef VOICE_STEAL_EN
    // Strictly-greater compare keeps the lowest index on equal ages.
    always_comb begin
        old_found_next = old_found_reg;
        old_idx_next   = old_idx_reg;
        old_age_next   = old_age_reg;
        if (cur_active && (!old_found_reg || (age_reg[scan_idx_reg] > old_age_reg))) begin
            old_found_next = 1'b1;
            old_idx_next   = scan_idx_reg;
            old_age_next   = age_reg[scan_idx_reg];
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Allocation policy
    // -----------------------------------------------------------------------
    always_comb begin
        dec_write = 1'b0;
        dec_gate  = 1'b0;
        dec_index = '0;
`ifdef VOICE_STEAL_EN
        dec_steal = 1'b0;
`endif
        if (on_lat_reg) begin
            if (match_found_next) begin
                dec_write = 1'b1;
                dec_gate  = 1'b1;
                dec_index = match_idx_next;
            end else if (free_found_next) begin
                dec_write = 1'b1;
                dec_gate  = 1'b1;
                dec_index = free_idx_next;
            end
`ifdef VOICE_STEAL_EN
            else if (old_found_next) begin
                dec_write = 1'b1;
                dec_gate  = 1'b1;
                dec_index = old_idx_next;
                dec_steal = 1'b1;
            end
`endif
        end else if (match_found_next) begin
            dec_write = 1'b1;
            dec_gate  = 1'b0;
            dec_index = match_idx_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM, event latch, candidates and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg        <= ST_IDLE;
            scan_idx_reg     <= '0;
            on_lat_reg       <= 1'b0;
            key_lat_reg      <= '0;
            tuning_lat_reg   <= '0;
            vel_lat_reg      <= '0;
            match_found_reg  <= 1'b0;
            match_idx_reg    <= '0;
            free_found_reg   <= 1'b0;
            free_idx_reg     <= '0;
            voice_wr_reg     <= 1'b0;
            drop_reg         <= 1'b0;
            voice_index_reg  <= '0;
            voice_gate_reg   <= 1'b0;
            voice_tuning_reg <= '0;
            voice_vel_reg    <= '0;
        end else begin
            voice_wr_reg <= 1'b0;
            drop_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_note_valid) begin
                        on_lat_reg      <= i_note_on && (i_velocity != 7'd0);
                        key_lat_reg     <= i_note_key;
                        tuning_lat_reg  <= i_tuning_code;
                        vel_lat_reg     <= i_velocity;
                        match_found_reg <= 1'b0;
                        free_found_reg  <= 1'b0;
                        scan_idx_reg    <= '0;
                        state_reg       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    match_found_reg <= match_found_next;
                    match_idx_reg   <= match_idx_next;
                    free_found_reg  <= free_found_next;
                    free_idx_reg    <= free_idx_next;
                    if (scan_last) begin
                        state_reg    <= ST_WRITE;
                        voice_wr_reg <= dec_write;
                        drop_reg     <= !dec_write;
                        if (dec_write) begin
                            voice_index_reg  <= dec_index;
                            voice_gate_reg   <= dec_gate;
                            voice_tuning_reg <= tuning_lat_reg;
                            voice_vel_reg    <= dec_gate ? vel_lat_reg : 7'd0;
                        end
                    end else begin
                        scan_idx_reg <= scan_idx_reg + VI_W'(1);
                    end
                end
                ST_WRITE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VOICE_STEAL_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            old_found_reg <= 1'b0;
            old_idx_reg   <= '0;
            old_age_reg   <= '0;
            steal_reg     <= 1'b0;
        end else begin
            steal_reg <= 1'b0;
            if ((state_reg == ST_IDLE) && i_note_valid) begin
                old_found_reg <= 1'b0;
            end else if (state_reg == ST_SCAN) begin
                old_found_reg <= old_found_next;
                old_idx_reg   <= old_idx_next;
                old_age_reg   <= old_age_next;
                if (scan_last) begin
                    steal_reg <= dec_steal;
                end
            end
        end
    end
    assign o_steal = steal_reg;
`else
    assign o_steal = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Table update, applied at the end of the WRITE cycle so that
    // o_active_mask changes on the cycle after the strobe.
    // -----------------------------------------------------------------------
    logic table_upd;
    assign table_upd = (state_reg == ST_WRITE) && voice_wr_reg;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic hit;
            assign hit = (voice_index_reg == VI_W'(gi));

            assign active_next[gi]  = (table_upd && hit) ? voice_gate_reg : active_reg[gi];
            assign key_tab_next[gi] = (table_upd && hit && voice_gate_reg) ? key_lat_reg
                                                                           : key_tab_reg[gi];
            // Ages move only on note-on writes: target restarts at zero,
            // other gated voices grow until they saturate.
            assign age_next[gi] = !(table_upd && voice_gate_reg) ? age_reg[gi] :
                                  hit                             ? '0 :
                                  (active_reg[gi] && (age_reg[gi] != AGE_MAX))
                                                                  ? age_reg[gi] + AGE_W'(1)
                                                                  : age_reg[gi];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            active_reg  <= '0;
            key_tab_reg <= '0;
            age_reg     <= '0;
        end else begin
            active_reg  <= active_next;
            key_tab_reg <= key_tab_next;
            age_reg     <= age_next;
        end
    end

    assign o_note_ready     = (state_reg == ST_IDLE);
    assign o_voice_wr       = voice_wr_reg;
    assign o_drop           = drop_reg;
    assign o_voice_index    = voice_index_reg;
    assign o_voice_gate     = voice_gate_reg;
    assign o_voice_tuning   = voice_tuning_reg;
    assign o_voice_velocity = voice_vel_reg;
    assign o_active_mask    = active_reg;

endmodule

// File: tb/tb_voice_allocator.sv
// ---------------------------------------------------------------------------
// tb_voice_allocator
//
// Scoreboard bench for voice_allocator with NUM_VOICES=4 and a small age
// width so saturation is reachable. The stimulus side applies each accepted
// event to a behavioural voice-pool model and queues the expected response;
// a monitor pops and compares whenever the DUT strobes o_voice_wr or o_drop,
// and checks o_active_mask on the following cycle.
// ---------------------------------------------------------------------------
module tb_voice_allocator;

    localparam int N   = 4;
    localparam int AW  = 3;
    localparam int VW  = 2;
    localparam int AGE_SAT = (1 << AW) - 1;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_note_valid = 1'b0;
    logic          o_note_ready;
    logic          i_note_on = 1'b0;
    logic [6:0]    i_note_key = '0;
    logic [31:0]   i_tuning_code = '0;
    logic [6:0]    i_velocity = '0;
    logic          o_voice_wr;
    logic [VW-1:0] o_voice_index;
    logic          o_voice_gate;
    logic [31:0]   o_voice_tuning;
    logic [6:0]    o_voice_velocity;
    logic [N-1:0]  o_active_mask;
    logic          o_steal;
    logic          o_drop;

    voice_allocator #(.NUM_VOICES(N), .AGE_W(AW)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_note_valid     (i_note_valid),
        .o_note_ready     (o_note_ready),
        .i_note_on        (i_note_on),
        .i_note_key       (i_note_key),
        .i_tuning_code    (i_tuning_code),
        .i_velocity       (i_velocity),
        .o_voice_wr       (o_voice_wr),
        .o_voice_index    (o_voice_index),
        .o_voice_gate     (o_voice_gate),
        .o_voice_tuning   (o_voice_tuning),
        .o_voice_velocity (o_voice_velocity),
        .o_active_mask    (o_active_mask),
        .o_steal          (o_steal),
        .o_drop           (o_drop)
    );

    initial forever #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model of the voice pool ----------------
    bit m_active[N];
    int m_key[N];
    int m_age[N];

    typedef struct {
        bit          wr;
        int          idx;
        bit          gate;
        logic [31:0] tun;
        int          vel;
        bit          steal;
        logic [N-1:0] mask;
        int          t_acc;
        string       tag;
    } exp_t;

    exp_t q[$];

    function automatic void model_clear();
        for (int v = 0; v < N; v++) begin
            m_active[v] = 0;
            m_key[v]    = 0;
            m_age[v]    = 0;
        end
    endfunction

    function automatic exp_t model_event(bit on, int key, int vel, logic [31:0] tun, int tacc, string tag);
        exp_t e;
        int match = -1, free = -1, oldest = -1, target = -1;
        e.wr = 0; e.idx = 0; e.gate = 0; e.tun = tun; e.vel = 0; e.steal = 0;
        e.t_acc = tacc; e.tag = tag;
        for (int v = 0; v < N; v++) begin
            if (m_active[v] && m_key[v] == key && match < 0) match = v;
            if (!m_active[v] && free < 0) free = v;
            if (m_active[v] && (oldest < 0 || m_age[v] > m_age[oldest])) oldest = v;
        end
        if (on && vel != 0) begin
            if (match >= 0) target = match;
            else if (free >= 0) target = free;
            else if (STEAL) begin
                target = oldest;
                e.steal = 1;
            end
            if (target >= 0) begin
                for (int v = 0; v < N; v++) begin
                    if (v == target) begin
                        m_active[v] = 1;
                        m_key[v]    = key;
                        m_age[v]    = 0;
                    end else if (m_active[v] && m_age[v] < AGE_SAT) begin
                        m_age[v]++;
                    end
                end
                e.wr = 1; e.idx = target; e.gate = 1; e.vel = vel;
            end
        end else if (match >= 0) begin
            m_active[match] = 0;
            e.wr = 1; e.idx = match; e.gate = 0; e.vel = 0;
        end
        for (int v = 0; v < N; v++) e.mask[v] = m_active[v];
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic [31:0] last_tun = '0;
    int          last_idx = 0;
    bit          mask_chk = 0;
    logic [N-1:0] mask_exp = '0;
    string       mask_tag;

    always @(negedge i_clk) begin
        if (i_reset) begin
            mask_chk = 0;
        end else begin
            if (mask_chk) begin
                check({mask_tag, "_mask"}, 64'(o_active_mask), 64'(mask_exp));
                mask_chk = 0;
            end
            if (o_voice_wr || o_drop) begin
                if (q.size() == 0) begin
                    check("unexpected_strobe", 64'({o_voice_wr, o_drop}), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check({e.tag, "_latency"}, 64'(cyc - e.t_acc), 64'(N + 1));
                    check({e.tag, "_wr"},    64'(o_voice_wr), 64'(e.wr));
                    check({e.tag, "_drop"},  64'(o_drop),     64'(!e.wr));
                    check({e.tag, "_steal"}, 64'(o_steal),    64'(e.steal));
                    if (e.wr) begin
                        check({e.tag, "_index"}, 64'(o_voice_index),    64'(e.idx));
                        check({e.tag, "_gate"},  64'(o_voice_gate),     64'(e.gate));
                        check({e.tag, "_tun"},   64'(o_voice_tuning),   64'(e.tun));
                        check({e.tag, "_vel"},   64'(o_voice_velocity), 64'(e.vel));
                        last_tun = e.tun;
                        last_idx = e.idx;
                    end else begin
                        check({e.tag, "_hold_tun"}, 64'(o_voice_tuning), 64'(last_tun));
                        check({e.tag, "_hold_idx"}, 64'(o_voice_index),  64'(last_idx));
                    end
                    mask_chk = 1;
                    mask_exp = e.mask;
                    mask_tag = e.tag;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        i_note_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        model_clear();
        q.delete();
        last_tun = '0;
        last_idx = 0;
    endtask

    task automatic send(input bit on, input int key, input int vel, input logic [31:0] tun,
                        input bit hold, input bit push, input string tag, output int tacc);
        int waited = 0;
        @(negedge i_clk);
        i_note_valid  = 1'b1;
        i_note_on     = on;
        i_note_key    = 7'(key);
        i_velocity    = 7'(vel);
        i_tuning_code = tun;
        while (!o_note_ready && waited < 50) begin
            @(negedge i_clk);
            waited++;
        end
        tacc = cyc;
        if (!o_note_ready) begin
            check({tag, "_ready_timeout"}, 64'(o_note_ready), 64'd1);
            i_note_valid = 1'b0;
        end else begin
            if (push) q.push_back(model_event(on, key, vel, tun, tacc, tag));
            @(posedge i_clk);
            #1;
            if (!hold) i_note_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int waited = 0;
        while (q.size() != 0 && waited < 100) begin
            @(negedge i_clk);
            waited++;
        end
        if (q.size() != 0) begin
            check("strobe_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        repeat (2) @(negedge i_clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t, t1, t2;
        do_reset();

        // Reset state
        check("rst_ready", 64'(o_note_ready), 64'd1);
        check("rst_wr",    64'(o_voice_wr),   64'd0);
        check("rst_drop",  64'(o_drop),       64'd0);
        check("rst_steal", 64'(o_steal),      64'd0);
        check("rst_index", 64'(o_voice_index), 64'd0);
        check("rst_tun",   64'(o_voice_tuning), 64'd0);
        check("rst_vel",   64'(o_voice_velocity), 64'd0);
        check("rst_gate",  64'(o_voice_gate), 64'd0);
        check("rst_mask",  64'(o_active_mask), 64'd0);

        // 1: first note-on
        send(1, 60, 100, 32'h0100_0000, 0, 1, "t1", t);
        wait_done();
        check("t1_lit_index", 64'(o_voice_index), 64'd0);
        check("t1_lit_vel",   64'(o_voice_velocity), 64'd100);
        check("t1_lit_mask",  64'(o_active_mask), 64'b0001);

        // 2: fill the pool, then one more
        send(1, 62, 90, 32'h0110_0000, 0, 1, "t2a", t);
        send(1, 64, 80, 32'h0120_0000, 0, 1, "t2b", t);
        send(1, 65, 70, 32'h0130_0000, 0, 1, "t2c", t);
        wait_done();
        check("t2_lit_mask_full", 64'(o_active_mask), 64'b1111);
        send(1, 67, 60, 32'h0140_0000, 0, 1, "t2_fifth", t);
        wait_done();
        check("t2_lit_mask_after", 64'(o_active_mask), 64'b1111);
        check("t2_lit_index", 64'(o_voice_index), STEAL ? 64'd0 : 64'd3);

        // 3: retrigger
        do_reset();
        send(1, 60, 100, 32'h0200_0000, 0, 1, "t3a", t);
        send(1, 62, 100, 32'h0210_0000, 0, 1, "t3b", t);
        send(1, 62, 50,  32'h0220_0000, 0, 1, "t3_retrig", t);
        wait_done();
        check("t3_lit_index", 64'(o_voice_index), 64'd1);
        check("t3_lit_mask",  64'(o_active_mask), 64'b0011);

        // 4: releases
        send(0, 60, 33, 32'h0300_0000, 0, 1, "t4_off", t);
        send(1, 60, 80, 32'h0310_0000, 0, 1, "t4_reon", t);
        send(1, 60, 0,  32'h0320_0000, 0, 1, "t4_vel0", t);
        wait_done();
        check("t4_lit_gate", 64'(o_voice_gate), 64'd0);
        check("t4_lit_vel",  64'(o_voice_velocity), 64'd0);
        send(0, 70, 10, 32'h0330_0000, 0, 1, "t4_miss", t);
        wait_done();

        // 5: valid held high across two events
        do_reset();
        send(1, 50, 40, 32'h0400_0000, 1, 1, "t5a", t1);
        send(1, 51, 41, 32'h0410_0000, 0, 1, "t5b", t2);
        check("t5_accept_gap", 64'(t2 - t1), 64'(N + 2));
        wait_done();

        // 6: reset in the middle of a scan
        send(1, 55, 20, 32'h0500_0000, 0, 1, "t6pre", t);
        wait_done();
        send(1, 56, 21, 32'h0510_0000, 0, 0, "t6", t);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        model_clear();
        q.delete();
        last_tun = '0;
        last_idx = 0;
        check("t6_ready", 64'(o_note_ready), 64'd1);
        check("t6_mask",  64'(o_active_mask), 64'd0);
        repeat (10) @(negedge i_clk);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            bit on;
            int key, vel;
            on  = ($urandom_range(0, 3) != 0);
            key = $urandom_range(60, 66);
            vel = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            send(on, key, vel, $urandom, ($urandom_range(0, 4) == 0), 1, "rnd", t);
        end
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Maps incoming MIDI note events from spi_controller onto a fixed pool of NUM_VOICES synth voices. The block keeps a per-voice table of active flag, key and age, and searches it sequentially, one voice per clock. Each accepted event produces at most one voice-write command to the voice datapath.
Policy: reuse a voice already holding the key, else take the lowest free voice, else steal the oldest voice. It sits between spi_controller and voice_controller.

Parameters:
NUM_VOICES, 8, number of voices in the pool (≥2); index width VI_W = clog2(NUM_VOICES)
AGE_W, 8, width of the per-voice saturating age counter

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_note_valid  in  1  event present
o_note_ready  out  1  block can accept an event
i_note_on  in  1  1 = note-on, 0 = note-off
i_note_key  in  7  MIDI key number
i_tuning_code  in  32  phase increment for the key
i_velocity  in  7  MIDI velocity
o_voice_wr  out  1  one-cycle write strobe to the voice datapath
o_voice_index  out  VI_W  target voice
o_voice_gate  out  1  1 = start or retrigger, 0 = release
o_voice_tuning  out  32  tuning code for the target voice
o_voice_velocity  out  7  velocity (0 on release)
o_active_mask  out  NUM_VOICES  bit v = voice v gated
o_steal  out  1  one-cycle pulse, coincident with o_voice_wr, when a voice was stolen
o_drop  out  1  one-cycle pulse when an event produces no write

Behaviour:
- Reset: table cleared (all inactive, key 0, age 0); FSM = IDLE.
- Reset output values: o_note_ready=1; o_voice_wr, o_steal, o_drop = 0; o_voice_index/tuning/velocity/gate = 0; o_active_mask = 0.
- Reset mid-search aborts the event with no write.
- Handshake: an event is accepted on a cycle with i_note_valid && o_note_ready. All event fields are latched on that cycle. o_note_ready is 0 from the cycle after acceptance through the WRITE/DONE cycle, and is 1 again on the following cycle. Unaccepted events are ignored; there is no queue.
- A note-on with i_velocity==0 is treated as a note-off.
- FSM states: IDLE -> SCAN (exactly NUM_VOICES cycles, voice 0..N-1, one per cycle) -> WRITE (1 cycle) -> IDLE.
- SCAN tracks three candidates:
  - match: lowest index with active && key==latched key;
  - free: lowest inactive index;
  - oldest: active voice with the largest age, ties to the lowest index.
- WRITE cycle, note-on, by priority:
  - match -> retrigger that voice;
  - else free -> allocate it;
  - else steal oldest and pulse o_steal.
  - The target gets active=1, key updated, age=0. All other active voices increment age, saturating at 2^AGE_W-1. Inactive voices keep age.
  - Outputs: o_voice_wr=1, gate=1, latched tuning and velocity.
- WRITE cycle, note-off:
  - match -> active=0; o_voice_wr=1, gate=0, velocity=0, tuning=latched value. Ages unchanged.
  - No match -> no write; o_drop=1 for that cycle.
- Latency: acceptance at cycle T; write or drop strobe at cycle T+NUM_VOICES+1; o_note_ready high at T+NUM_VOICES+2.
- o_voice_* data fields hold their values between strobes.
- o_active_mask is registered and reflects the table update on the cycle after WRITE.

Optional Feature:
VOICE_STEAL_EN
- Defined: the note-on steal policy applies as described under Behaviour.
- Undefined: a note-on with no match and no free voice produces no write; o_drop pulses in the WRITE cycle; the table and ages are unchanged. o_steal is tied to 0.

Test Plan:
1. NUM_VOICES=4. After reset, note-on key 60, vel 100, tuning 0x0100_0000 -> o_note_ready=1 at reset; write strobe exactly 5 cycles after acceptance with index 0, gate=1, vel 100, tuning 0x0100_0000; o_active_mask=0001 on the next cycle.
2. Note-ons keys 60, 62, 64, 65 -> indices 0, 1, 2, 3; mask=1111. A fifth note-on key 67 -> index 0 (oldest) with o_steal=1. Without VOICE_STEAL_EN: no write, o_drop=1, mask stays 1111.
3. Keys 60, 62 active; note-on key 62 again, vel 50 -> retrigger index 1, gate=1, vel 50; no new voice used (mask stays 0011).
4. Note-off key 60 (and, separately, note-on key 60 vel 0) -> index 0, gate=0, vel 0. Note-off key 70 (inactive) -> no write, o_drop=1.
5. i_note_valid held high continuously for two events -> the second is not accepted until o_note_ready returns (cycle T+6 for N=4); exactly two write strobes.
6. i_reset asserted during SCAN -> no o_voice_wr; next cycle o_note_ready=1 and o_active_mask=0.
